sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side responder for the pipeline's MEM stage. Accepts the stage's level-held `mem_read`/`mem_write` requests and completes each request as two 16-bit accesses to an external asynchronous SRAM, with programmable wait states. Drives `ready` back to the core; the core freezes every pipeline stage while `ready` is low. Sits between the MEM stage and the board SRAM pins, replacing the on-chip data memory.

## Interface
- `WAIT_CYCLES`, 3: cycles each 16-bit half-access is held on the SRAM pins; minimum 1.
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.

- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_read` in 1: read request, held by the core until `ready`.
- `mem_write` in 1: write request, held by the core until `ready`.
- `address` in 32: byte address, word-aligned.
- `write_data` in 32: write word, held with `mem_write`.
- `read_data` out 32: registered read word.
- `ready` out 1: request complete; low = freeze the pipeline.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_WE_N` out 1: write enable, active-low.
- `SRAM_OE_N` out 1: output enable, active-low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: tied 0.

## Operation
- Index arithmetic:
  - `idx = (address - BASE_ADDR) >> 2`, computed modulo 2^32.
  - Low half goes to `SRAM_ADDR = {idx[16:0],1'b0}`; high half to `{idx[16:0],1'b1}`.
  - Upper index bits are discarded; out-of-range addresses wrap silently.
- States: IDLE, LOW, HIGH, DONE. A counter of width `$clog2(WAIT_CYCLES+1)` counts cycles within LOW and HIGH.
- IDLE:
  - `ready = !(mem_read | mem_write)`.
  - On any request: latch the op (write if `mem_write`, including when both are high), `idx`, and `write_data`; clear the counter; go to LOW.
- LOW: `SRAM_ADDR` = low-half address.
  - Write: drive `SRAM_DQ = wdata[15:0]`, `SRAM_WE_N = 0`, `SRAM_OE_N = 1`.
  - Read: `SRAM_DQ` is Z, `SRAM_OE_N = 0`, `SRAM_WE_N = 1`.
  - On counter == `WAIT_CYCLES-1`: a read captures `SRAM_DQ` into `read_data[15:0]`; go to HIGH with the counter cleared.
- HIGH: same as LOW but with the high-half address and `wdata[31:16]`; a read captures into `read_data[31:16]`; go to DONE.
- DONE:
  - `ready = 1`, `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, bus Z.
  - Next state is always IDLE. The core advances on this edge, so a request seen in the following IDLE cycle is a new transaction.
- Outside an access phase: `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, `SRAM_DQ` = Z.
- Request inputs are ignored in LOW, HIGH and DONE. Dropping the request mid-transaction does not abort it.
- `read_data` changes only on read captures and holds its value across writes.

## Timing
- Reset (asynchronous, `rst` = 0) forces:
  - state IDLE, counter 0, `read_data = 0`, latched op/index/data = 0;
  - `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, bus Z;
  - `ready = !(mem_read | mem_write)`.
- Latency, with request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W; HIGH occupies W+1..2W; DONE is cycle 2W+1.
  - `ready` is low for cycles 0..2W and high in cycle 2W+1, i.e. 2W+2 cycles per access.
- `read_data` is stable from cycle 2W+1 until the next read's capture.
- Reset asserted mid-transaction:
  - immediate return to the reset values above;
  - any write in flight may leave one half written;
  - no partial `read_data` survives.
- Back-to-back requests: one IDLE cycle with `ready` low separates DONE from the next LOW.
- `ready` is combinational from the request inputs only in IDLE.

## Test plan
- Write at 1024: `write_data = 0xDEADBEEF`, W=3.
  - SRAM[0] = 0xBEEF, SRAM[1] = 0xDEAD.
  - `SRAM_WE_N` low for cycles 1..6.
  - `ready` low for cycles 0..6, high at cycle 7.
- Read at 1024 after the write: `read_data = 0xDEADBEEF` at cycle 7. `SRAM_OE_N` low for cycles 1..6; `SRAM_WE_N` stays 1.
- Address translation: writes at 1028 and 1024+4·0x1FFFF.
  - 1028 hits SRAM halfwords 2/3.
  - 1024+4·0x1FFFF hits 0x3FFFE/0x3FFFF.
  - Address 1020 wraps to 0x3FFFE/0x3FFFF.
- Back-to-back: write 0x12345678 at 1032, then read 1032 with no idle gap from the core.
  - Second transaction's LOW starts 2 cycles after the first DONE.
  - `read_data = 0x12345678`.
- Both `mem_read` and `mem_write` high: the request is treated as a write; `read_data` is unchanged.
- Reset mid-write: `rst` = 0 during HIGH cycle 5.
  - `SRAM_WE_N = 1` and bus Z immediately.
  - After release, state is IDLE and `read_data = 0`.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/sram_controller.sv
// MEM-stage responder: each 32-bit request becomes two 16-bit accesses to an
// external async SRAM, with WAIT_CYCLES wait states per half.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_wr_q, op_wr_d;
  logic [16:0]   idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          dq_oe;
  logic [15:0]   dq_out;
  logic          req;
  logic [16:0]   idx_in;

  // Out-of-range addresses wrap: only the low 17 word-index bits survive.
  assign idx_in = 17'((address - BASE_ADDR) >> 2);
  assign req    = mem_read | mem_write;

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = {idx_q, 1'b0};
    dq_oe     = 1'b0;
    dq_out    = wdata_q[15:0];
    unique case (state_q)
      IDLE: begin
        ready = !req;
        if (req) begin
          op_wr_d = mem_write;
          idx_d   = idx_in;
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        SRAM_ADDR = {idx_q, 1'b0};
        dq_out    = wdata_q[15:0];
        dq_oe     = op_wr_q;
        SRAM_WE_N = !op_wr_q;
        SRAM_OE_N = op_wr_q;
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        SRAM_ADDR = {idx_q, 1'b1};
        dq_out    = wdata_q[31:16];
        dq_oe     = op_wr_q;
        SRAM_WE_N = !op_wr_q;
        SRAM_OE_N = op_wr_q;
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async SRAM model on the pins plus a word-level
// reference memory; directed plan steps followed by random traffic.
module tb_sram_controller;

  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N, SRAM_OE_N;
  logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sram [0:262143] = '{default: 16'h0};
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR] : 16'hzzzz;

  always @(posedge clk)
    if (!SRAM_WE_N && !SRAM_CE_N) sram[SRAM_ADDR] <= SRAM_DQ;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return (d / 4) % 32'h20000;
  endfunction

  // One core request held until ready; checks timing, pins and results.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd);
    int unsigned k;
    int hi_at, we_cnt, oe_cnt, win_bad;
    logic [17:0] a_lo, a_hi;
    k = widx(a);
    hi_at = -1; we_cnt = 0; oe_cnt = 0; win_bad = 0;
    a_lo = '0; a_hi = '0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; address = a; write_data = wd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!SRAM_WE_N) begin
        we_cnt++;
        if (c < 1 || c > 2 * W) win_bad = 1;
      end
      if (!SRAM_OE_N) begin
        oe_cnt++;
        if (c < 1 || c > 2 * W) win_bad = 1;
      end
      if (c == 1) a_lo = SRAM_ADDR;
      if (c == W + 1) a_hi = SRAM_ADDR;
      if (ready) begin
        hi_at = c;
        break;
      end
    end
    chk("ready_cycle", hi_at, 2 * W + 1);
    chk("we_low_cycles", we_cnt, wr ? 2 * W : 0);
    chk("oe_low_cycles", oe_cnt, (rd && !wr) ? 2 * W : 0);
    chk("strobe_window", win_bad, 0);
    chk("addr_low", {14'h0, a_lo}, k * 2);
    chk("addr_high", {14'h0, a_hi}, k * 2 + 1);
    if (wr) begin
      ref_mem[k] = wd;
      chk("sram_lo", {16'h0, sram[k*2]}, {16'h0, wd[15:0]});
      chk("sram_hi", {16'h0, sram[k*2+1]}, {16'h0, wd[31:16]});
    end else begin
      exp_rd = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    end
    chk("read_data", read_data, exp_rd);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int unsigned j;
    logic [31:0] ra;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_oe_n", SRAM_OE_N, 1);
    chk("rst_read_data", read_data, 0);
    @(posedge clk); #1 rst = 1'b1;
    idle(1);

    txn(0, 1, 32'd1024, 32'hDEADBEEF);
    chk("plan_sram0", {16'h0, sram[0]}, 32'h0000BEEF);
    chk("plan_sram1", {16'h0, sram[1]}, 32'h0000DEAD);
    idle(1);
    txn(1, 0, 32'd1024, 32'h0);
    chk("plan_read", read_data, 32'hDEADBEEF);
    idle(2);

    txn(0, 1, 32'd1028, 32'hCAFEF00D);
    chk("xl_1028", {16'h0, sram[3]}, 32'h0000CAFE);
    idle(1);
    txn(0, 1, 32'd1024 + 32'd4 * 32'h1FFFF, 32'hA5A51234);
    idle(1);
    txn(0, 1, 32'd1020, 32'h0BADC0DE);
    chk("xl_wrap", {16'h0, sram[18'h3FFFF]}, 32'h00000BAD);
    idle(1);
    txn(1, 0, 32'd1024 + 32'd4 * 32'h1FFFF, 32'h0);
    idle(1);

    txn(0, 1, 32'd1032, 32'h12345678);
    txn(1, 0, 32'd1032, 32'h0);
    chk("b2b_read", read_data, 32'h12345678);
    txn(1, 1, 32'd1036, 32'h55AA33CC);
    chk("both_is_write", read_data, 32'h12345678);
    idle(1);
    txn(1, 0, 32'd1036, 32'h0);
    idle(1);

    for (int n = 0; n < 30; n++) begin
      j = $urandom_range(0, 15);
      ra = BASE + j * 4;
      if ($urandom_range(0, 1) == 1)
        txn(0, 1, ra, $urandom);
      else
        txn(1, 0, ra, 32'h0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
    end
    idle(1);
    txn(1, 0, 32'd1032, 32'h0);
    idle(1);

    ra = BASE + 32'd4 * 32'h100;
    @(posedge clk); #1;
    mem_write = 1'b1; address = ra; write_data = 32'h77778888;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_we_active", SRAM_WE_N, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_we_n", SRAM_WE_N, 1);
    chk("mid_rst_oe_n", SRAM_OE_N, 1);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_rdata", read_data, 0);
    mem_write = 1'b0;
    #1;
    chk("mid_rst_idle_ready", ready, 1);
    ref_mem.delete(widx(ra));
    exp_rd = '0;
    @(posedge clk); #1 rst = 1'b1;
    txn(1, 0, 32'd1024, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
